wb_stream_bridge: RTL

Wishbone-slave front end for the AI accelerator core. The management SoC pushes 32-bit operand words into an input FIFO, which drains to the compute core over a valid/ready stream. Results from the core are caught in a one-entry holding register that the SoC reads back. A status register exposes fill level and error flags. The block sits between the user-area Wishbone port and the accelerator datapath.

---
 rtl/wb_stream_bridge_pkg.sv | 21 ++
 rtl/wb_stream_bridge_sync_fifo.sv | 58 +++++
 rtl/wb_stream_bridge.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_stream_bridge_pkg.sv
// Shared register offsets and bit positions for the Wishbone-to-stream bridge.
package wb_stream_bridge_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_PUSH   = 8'h08;
  localparam logic [7:0] REG_RESULT = 8'h0C;

  localparam int unsigned CTRL_EN       = 32'd0;
  localparam int unsigned CTRL_FLUSH    = 32'd1;
  localparam int unsigned CTRL_CLR_OVF  = 32'd2;
  localparam int unsigned CTRL_IRQ_MASK = 32'd3;

  localparam int unsigned ST_FULL      = 32'd8;
  localparam int unsigned ST_EMPTY     = 32'd9;
  localparam int unsigned ST_OVF       = 32'd10;
  localparam int unsigned ST_RES_VALID = 32'd11;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_stream_bridge_sync_fifo.sv
// Power-of-two synchronous FIFO: storage, pointers and occupancy only.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_s;
  logic             rd_s;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_s  = push & (~full | pop);
  assign rd_s  = pop & ~empty;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (rd_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_stream_bridge.sv
// Wishbone slave feeding an operand FIFO to the accelerator and holding one result.
// Optional interrupt output is enabled by defining WB_STREAM_BRIDGE_IRQ_EN.
module wb_stream_bridge
  import wb_stream_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3200_0000,
  parameter int          DEPTH     = 16,
  localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  input  logic        s_res_valid,
  input  logic [31:0] s_res_data,
  output logic        s_res_ready
`ifdef WB_STREAM_BRIDGE_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic             ack_r;
  logic [31:0]      dat_r;
  logic             enable_r;
  logic             overflow_r;
  logic             res_valid_r;
  logic [31:0]      res_data_r;
  logic             hit_s;
  logic             rd_hit_s;
  logic             ctrl_wr_s;
  logic             push_req_s;
  logic             pop_s;
  logic             flush_s;
  logic             clr_ovf_s;
  logic             ovf_set_s;
  logic             res_rd_s;
  logic             capture_s;
  logic [7:0]       off_s;
  logic [31:0]      rd_data_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;

  // Ack blocks a second hit, giving one transfer per two cycles.
  assign hit_s      = wbs_stb_i & wbs_cyc_i & ~ack_r
                      & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off_s      = wbs_adr_i[7:0];
  assign rd_hit_s   = hit_s & ~wbs_we_i;
  assign ctrl_wr_s  = hit_s & wbs_we_i & (off_s == REG_CTRL) & wbs_sel_i[0];
  assign push_req_s = hit_s & wbs_we_i & (off_s == REG_PUSH) & (wbs_sel_i == SEL_ALL);
  assign pop_s      = m_valid & m_ready;
  assign flush_s    = ctrl_wr_s & wbs_dat_i[CTRL_FLUSH];
  assign clr_ovf_s  = ctrl_wr_s & wbs_dat_i[CTRL_CLR_OVF];
  assign ovf_set_s  = push_req_s & fifo_full_s & ~pop_s;
  assign res_rd_s   = rd_hit_s & (off_s == REG_RESULT) & res_valid_r;
  assign capture_s  = s_res_valid & ~res_valid_r;

  assign wbs_ack_o   = ack_r;
  assign wbs_dat_o   = dat_r;
  assign m_valid     = enable_r & ~fifo_empty_s;
  assign s_res_ready = ~res_valid_r;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (push_req_s),
    .pop     (pop_s),
    .flush   (flush_s),
    .data_in (wbs_dat_i),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s),
    .head    (m_data)
  );

`ifdef WB_STREAM_BRIDGE_IRQ_EN
  logic irq_mask_r;
  logic irq_r;

  assign irq = irq_r;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_mask_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      if (ctrl_wr_s) irq_mask_r <= wbs_dat_i[CTRL_IRQ_MASK];
      irq_r <= (res_valid_r | overflow_r) & ~irq_mask_r;
    end
  end
`endif

  always_comb begin
    rd_data_s = 32'h0;
    case (off_s)
      REG_CTRL: begin
        rd_data_s[CTRL_EN] = enable_r;
`ifdef WB_STREAM_BRIDGE_IRQ_EN
        rd_data_s[CTRL_IRQ_MASK] = irq_mask_r;
`endif
      end
      REG_STATUS: begin
        rd_data_s[7:0]          = 8'(fifo_count_s);
        rd_data_s[ST_FULL]      = fifo_full_s;
        rd_data_s[ST_EMPTY]     = fifo_empty_s;
        rd_data_s[ST_OVF]       = overflow_r;
        rd_data_s[ST_RES_VALID] = res_valid_r;
      end
      REG_RESULT: begin
        if (res_valid_r) rd_data_s = res_data_r;
        else             rd_data_s = 32'h0;
      end
      default: rd_data_s = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r       <= 1'b0;
      dat_r       <= 32'h0;
      enable_r    <= 1'b0;
      overflow_r  <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= 32'h0;
    end else begin
      ack_r <= hit_s;
      dat_r <= rd_hit_s ? rd_data_s : 32'h0;
      if (ctrl_wr_s) enable_r <= wbs_dat_i[CTRL_EN];
      // A same-cycle overflow beats a clear request.
      if (ovf_set_s)      overflow_r <= 1'b1;
      else if (clr_ovf_s) overflow_r <= 1'b0;
      if (capture_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= s_res_data;
      end else if (res_rd_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

endmodule
